// File: rtl/dac_tracking_fifo.sv
// Single-clock byte FIFO feeding the PMOD DAC consumer. It exports raw pointers,
// cumulative byte counters, fill level and sticky overflow/underflow flags.
module dac_tracking_fifo #(
  parameter int          ADDR_WIDTH     = 11,
  parameter logic [7:0]  UNDERFLOW_BYTE = 8'h00,
  parameter int          LOW_WATER      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_write,
  input  logic                  fifo_read,
  output logic [7:0]            fifo_data,
  output logic [ADDR_WIDTH-1:0] fifo_addr_in,
  output logic [ADDR_WIDTH-1:0] fifo_addr_out,
  output logic [31:0]           write_fifo_byte_count,
  output logic [31:0]           read_fifo_byte_count,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  empty,
  output logic                  full,
  output logic                  low_water,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_flags
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LOW_LEVEL = (ADDR_WIDTH+1)'(LOW_WATER);

  logic [7:0]            r_mem [DEPTH];
  logic [7:0]            r_data;
  logic [ADDR_WIDTH-1:0] r_addr_in;
  logic [ADDR_WIDTH-1:0] r_addr_out;
  logic [ADDR_WIDTH:0]   r_fill;
  logic [31:0]           r_wr_cnt;
  logic [31:0]           r_rd_cnt;
  logic                  r_ovf;
  logic                  r_unf;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_evt;
  logic w_unf_evt;

  // Status comes only from registered state, never from this cycle's strobes.
  assign w_empty   = (r_fill == '0);
  assign w_full    = (r_fill == FILL_MAX);
  assign w_rd_acc  = fifo_read && !w_empty;
  // A read that frees a slot this cycle lets a write into a full FIFO.
  assign w_wr_acc  = in_write && (!w_full || w_rd_acc);
  assign w_ovf_evt = in_write && !w_wr_acc;
  assign w_unf_evt = fifo_read && w_empty;

  // NOTE: RAM array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_addr_in] <= in_data;
  end

  // NOTE: non-blocking assignments everywhere here, so the RAM read below sees the
  // pre-write contents when read and write hit the same slot on a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_addr_in  <= '0;
      r_addr_out <= '0;
      r_fill     <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (fifo_read) r_data <= w_empty ? UNDERFLOW_BYTE : r_mem[r_addr_out];

      if (w_wr_acc) begin
        r_addr_in <= r_addr_in + ADDR_WIDTH'(1);
        r_wr_cnt  <= r_wr_cnt + 32'd1;
      end
      if (w_rd_acc) begin
        r_addr_out <= r_addr_out + ADDR_WIDTH'(1);
        r_rd_cnt   <= r_rd_cnt + 32'd1;
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill <= r_fill + (ADDR_WIDTH+1)'(1);
        2'b01:   r_fill <= r_fill - (ADDR_WIDTH+1)'(1);
        default: r_fill <= r_fill;
      endcase

      // A new event in the same cycle as clear_flags keeps the flag set.
      if (w_ovf_evt)        r_ovf <= 1'b1;
      else if (clear_flags) r_ovf <= 1'b0;
      if (w_unf_evt)        r_unf <= 1'b1;
      else if (clear_flags) r_unf <= 1'b0;
    end
  end

  assign fifo_data             = r_data;
  assign fifo_addr_in          = r_addr_in;
  assign fifo_addr_out         = r_addr_out;
  assign write_fifo_byte_count = r_wr_cnt;
  assign read_fifo_byte_count  = r_rd_cnt;
  assign fill_level            = r_fill;
  assign empty                 = w_empty;
  assign full                  = w_full;
  assign low_water             = (r_fill < LOW_LEVEL);
  assign overflow              = r_ovf;
  assign underflow             = r_unf;

endmodule
